// File: rtl/uart_rx_fifo.sv
// UART receiver with majority-voted sampling, per-frame error tags, break
// detection and a show-ahead receive FIFO, all in the single clk domain.
module uart_rx_fifo #(
    parameter int unsigned CLK_CYCLES_PER_BIT = 219,
    parameter int unsigned DATA_BITS          = 8,
    parameter int unsigned PARITY_MODE        = 0,
    parameter int unsigned STOP_BITS          = 1,
    parameter int unsigned SYNC_STAGES        = 3,
    parameter int unsigned FIFO_DEPTH         = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          rx_data,
    input  logic                          rd_en,
    output logic                          rd_valid,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_perr,
    output logic                          rd_ferr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          break_det,
    output logic                          overrun,
    input  logic                          err_clr
);

    localparam int unsigned CW = $clog2(CLK_CYCLES_PER_BIT);
    localparam int unsigned M  = (CLK_CYCLES_PER_BIT - 1) / 2;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned EW = DATA_BITS + 2;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreakWait
    } state_e;

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;

    // Shift the asynchronous line through the flop chain; idles high.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_data};
        end
    end

    assign rxs = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic                 s0_q, s0_d, s1_q, s1_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 break_q;

    logic                 at_lo, at_mid, at_hi, at_end;
    logic                 maj, ferr_fin;
    logic                 push_req, brk_pulse;
    logic [EW-1:0]        push_word;

    assign at_lo  = (cnt_q == CW'(M - 1));
    assign at_mid = (cnt_q == CW'(M));
    assign at_hi  = (cnt_q == CW'(M + 1));
    assign at_end = (cnt_q == CW'(CLK_CYCLES_PER_BIT - 1));

    // Third vote is the live line at cnt = M+1, so the bit decision lands there.
    assign maj      = (s0_q & s1_q) | (s0_q & rxs) | (s1_q & rxs);
    assign ferr_fin = ferr_q | ~maj;
    assign push_word = {perr_q, ferr_fin, shreg_q};

    // FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            s0_q    <= 1'b1;
            s1_q    <= 1'b1;
            shreg_q <= '0;
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            break_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            break_q <= brk_pulse;
        end
    end

    // Next-state, bit sampling and frame completion decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = (at_end) ? '0 : cnt_q + CW'(1);
        bit_d     = bit_q;
        s0_d      = (at_lo) ? rxs : s0_q;
        s1_d      = (at_mid) ? rxs : s1_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        push_req  = 1'b0;
        brk_pulse = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d  = '0;
                bit_d  = '0;
                par_d  = 1'b0;
                perr_d = 1'b0;
                ferr_d = 1'b0;
                if (!rxs) begin
                    state_d = StStart;
                end
            end

            StStart: begin
                if (at_hi && maj) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (at_end) begin
                    state_d = StData;
                end
            end

            StData: begin
                if (at_hi) begin
                    shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
                end
                if (at_end) begin
                    if (bit_q == 4'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY_MODE != 0) ? StParity : StStop;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end

            StParity: begin
                if (at_hi) begin
                    par_d  = maj;
                    perr_d = ((maj ^ (^shreg_q)) != (PARITY_MODE == 1));
                end
                if (at_end) begin
                    bit_d   = '0;
                    state_d = StStop;
                end
            end

            StStop: begin
                if (at_hi) begin
                    ferr_d = ferr_fin;
                end
                // Final stop bit completes at mid-bit so a following start edge is not missed.
                if (at_hi && (bit_q == 4'(STOP_BITS - 1))) begin
                    cnt_d = '0;
                    if ((shreg_q == '0) && !par_q && ferr_fin) begin
                        brk_pulse = 1'b1;
                        state_d   = StBreakWait;
                    end else begin
                        push_req = 1'b1;
                        state_d  = StIdle;
                    end
                end else if (at_end) begin
                    bit_d = bit_q + 4'd1;
                end
            end

            StBreakWait: begin
                cnt_d = '0;
                if (rxs) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    assign break_det = break_q;

    // ------------------------------------------------------------------
    // Show-ahead receive FIFO
    // ------------------------------------------------------------------
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   level_q, level_d;
    logic          overrun_q, overrun_d;
    logic          full, pop, push;

    assign rd_valid = (level_q != '0);
    assign full     = (level_q == (PW + 1)'(FIFO_DEPTH));
    assign pop      = rd_en & rd_valid;
    // A pop in the same cycle frees the slot the incoming frame needs.
    assign push     = push_req & (~full | pop);

    // Level and sticky overrun next state; a new overrun beats err_clr.
    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + (PW + 1)'(1);
        end else if (pop && !push) begin
            level_d = level_q - (PW + 1)'(1);
        end
        overrun_d = overrun_q;
        if (push_req && full && !pop) begin
            overrun_d = 1'b1;
        end else if (err_clr) begin
            overrun_d = 1'b0;
        end
    end

    // Pointer, level and overrun registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            level_q   <= level_d;
            overrun_q <= overrun_d;
        end
    end

    // Entry storage; contents are only observed while the entry is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= push_word;
        end
    end

    assign {rd_perr, rd_ferr, rd_data} = mem[rd_ptr_q];
    assign fifo_level = level_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: an 8N1 instance and an 8E1 instance,
// with a scoreboard of expected FIFO entries per instance.
module tb_uart_rx_fifo;

    localparam int CPB = 219;
    localparam int M   = (CPB - 1) / 2;
    localparam int S   = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn;
    logic       rx0, rx1, rd_en0, rd_en1, err_clr0, err_clr1;
    logic       rd_valid0, rd_valid1, rd_perr0, rd_perr1, rd_ferr0, rd_ferr1;
    logic       break_det0, break_det1, overrun0, overrun1;
    logic [7:0] rd_data0, rd_data1;
    logic [4:0] fifo_level0, fifo_level1;
    logic [9:0] head0, head1;

    assign head0 = {rd_perr0, rd_ferr0, rd_data0};
    assign head1 = {rd_perr1, rd_ferr1, rd_data1};

    uart_rx_fifo #(
        .CLK_CYCLES_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0),
        .STOP_BITS(1), .SYNC_STAGES(S), .FIFO_DEPTH(16)
    ) dut0 (
        .clk(clk), .resetn(resetn), .rx_data(rx0), .rd_en(rd_en0),
        .rd_valid(rd_valid0), .rd_data(rd_data0), .rd_perr(rd_perr0),
        .rd_ferr(rd_ferr0), .fifo_level(fifo_level0), .break_det(break_det0),
        .overrun(overrun0), .err_clr(err_clr0)
    );

    uart_rx_fifo #(
        .CLK_CYCLES_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2),
        .STOP_BITS(1), .SYNC_STAGES(S), .FIFO_DEPTH(16)
    ) dut1 (
        .clk(clk), .resetn(resetn), .rx_data(rx1), .rd_en(rd_en1),
        .rd_valid(rd_valid1), .rd_data(rd_data1), .rd_perr(rd_perr1),
        .rd_ferr(rd_ferr1), .fifo_level(fifo_level1), .break_det(break_det1),
        .overrun(overrun1), .err_clr(err_clr1)
    );

    int checks = 0;
    int errors = 0;
    int brk_cnt = 0;
    logic [9:0] q0[$];
    logic [9:0] q1[$];

    always @(posedge clk) begin
        if (break_det0 === 1'b1) brk_cnt <= brk_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; n falling edges pass before return.
    task automatic drive(input int sel, input logic v, input int n);
        if (sel == 0) rx0 = v; else rx1 = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_head(input int sel, input logic [7:0] d);
        drive(sel, 1'b0, CPB);
        for (int i = 0; i < 8; i++) drive(sel, d[i], CPB);
    endtask

    task automatic send_frame(input int sel, input logic [7:0] d, input logic par_en,
                              input logic pb, input logic stop_v, input int idle_bits);
        send_head(sel, d);
        if (par_en) drive(sel, pb, CPB);
        drive(sel, stop_v, CPB);
        drive(sel, 1'b1, idle_bits * CPB);
    endtask

    // Wait (bounded) for a valid head, compare it with the scoreboard, then pop.
    task automatic pop_check(input int sel, input string tag);
        int         t;
        logic       v;
        logic [9:0] exp;
        t = 0;
        v = (sel == 0) ? rd_valid0 : rd_valid1;
        while (v !== 1'b1 && t < 4 * CPB) begin
            @(negedge clk);
            t++;
            v = (sel == 0) ? rd_valid0 : rd_valid1;
        end
        chk({tag, " rd_valid"}, {31'd0, v}, 32'd1);
        checks++;
        assert ((sel == 0) ? (q0.size() != 0) : (q1.size() != 0)) else begin
            errors++;
            $error("FAIL %s scoreboard: observed empty queue expected an entry", tag);
        end
        if (sel == 0 && q0.size() != 0) begin
            exp = q0.pop_front();
            chk({tag, " entry"}, {22'd0, head0}, {22'd0, exp});
            rd_en0 = 1'b1;
            @(negedge clk);
            rd_en0 = 1'b0;
        end else if (sel == 1 && q1.size() != 0) begin
            exp = q1.pop_front();
            chk({tag, " entry"}, {22'd0, head1}, {22'd0, exp});
            rd_en1 = 1'b1;
            @(negedge clk);
            rd_en1 = 1'b0;
        end
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        resetn = 1'b0;
        rx0 = 1'b1; rx1 = 1'b1;
        rd_en0 = 1'b0; rd_en1 = 1'b0;
        err_clr0 = 1'b0; err_clr1 = 1'b0;
        repeat (5) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        chk("reset rd_valid0", {31'd0, rd_valid0}, 32'd0);
        chk("reset level0", {27'd0, fifo_level0}, 32'd0);
        chk("reset break0", {31'd0, break_det0}, 32'd0);
        chk("reset overrun0", {31'd0, overrun0}, 32'd0);
        chk("reset rd_valid1", {31'd0, rd_valid1}, 32'd0);
        chk("reset level1", {27'd0, fifo_level1}, 32'd0);

        // 8N1 0x55 with exact latency from the stop-bit midpoint.
        d = 8'h55;
        send_head(0, d);
        q0.push_back({2'b00, d});
        drive(0, 1'b1, M + 1);
        drive(0, 1'b1, S + 1);
        chk("latency early", {31'd0, rd_valid0}, 32'd0);
        drive(0, 1'b1, 1);
        chk("latency on time", {31'd0, rd_valid0}, 32'd1);
        chk("level after 0x55", {27'd0, fifo_level0}, 32'd1);
        drive(0, 1'b1, CPB - M - S - 3);
        pop_check(0, "frame 0x55");
        chk("level after pop", {27'd0, fifo_level0}, 32'd0);

        // Even parity: 0xA3 has four ones, so parity bit 1 is wrong.
        send_frame(1, 8'hA3, 1'b1, 1'b1, 1'b1, 1);
        q1.push_back({2'b10, 8'hA3});
        pop_check(1, "parity wrong");
        send_frame(1, 8'hA3, 1'b1, 1'b0, 1'b1, 1);
        q1.push_back({2'b00, 8'hA3});
        pop_check(1, "parity right");

        // Short low glitch is a false start.
        drive(0, 1'b0, 50);
        drive(0, 1'b1, 2 * CPB);
        chk("glitch no push", {31'd0, rd_valid0}, 32'd0);
        chk("glitch level", {27'd0, fifo_level0}, 32'd0);
        chk("glitch no break", brk_cnt, 32'd0);
        chk("glitch no overrun", {31'd0, overrun0}, 32'd0);
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, 1);
        q0.push_back({2'b00, 8'h3C});
        pop_check(0, "frame 0x3C");

        // Framing error, then a break, then a normal frame.
        send_frame(0, 8'h81, 1'b0, 1'b0, 1'b0, 2);
        q0.push_back({2'b01, 8'h81});
        pop_check(0, "ferr 0x81");
        drive(0, 1'b0, 14 * CPB);
        drive(0, 1'b1, 2 * CPB);
        chk("break pulses", brk_cnt, 32'd1);
        chk("break no push", {31'd0, rd_valid0}, 32'd0);
        send_frame(0, 8'h12, 1'b0, 1'b0, 1'b1, 1);
        q0.push_back({2'b00, 8'h12});
        pop_check(0, "after break 0x12");

        // Inverted single-cycle glitch on the receiver's middle sample of each data bit
        // (the receiver's count lags the line by one sample after start detection).
        d = 8'hF0;
        drive(0, 1'b0, CPB);
        for (int i = 0; i < 8; i++) begin
            drive(0, d[i], M + 1);
            drive(0, ~d[i], 1);
            drive(0, d[i], CPB - M - 2);
        end
        drive(0, 1'b1, 2 * CPB);
        q0.push_back({2'b00, d});
        pop_check(0, "vote 0xF0");

        // Fill past capacity with no reads.
        for (int i = 0; i < 17; i++) begin
            d = 8'(i);
            send_frame(0, d, 1'b0, 1'b0, 1'b1, 0);
            if (i < 16) q0.push_back({2'b00, d});
        end
        drive(0, 1'b1, CPB);
        chk("full level", {27'd0, fifo_level0}, 32'd16);
        chk("overrun set", {31'd0, overrun0}, 32'd1);
        err_clr0 = 1'b1;
        @(negedge clk);
        err_clr0 = 1'b0;
        chk("overrun cleared", {31'd0, overrun0}, 32'd0);

        // Push and pop land on the same edge while full.
        d = 8'h11;
        send_head(0, d);
        drive(0, 1'b1, M + 1);
        drive(0, 1'b1, S + 1);
        chk("head before pop", {22'd0, head0}, {22'd0, q0.pop_front()});
        rd_en0 = 1'b1;
        drive(0, 1'b1, 1);
        rd_en0 = 1'b0;
        q0.push_back({2'b00, d});
        chk("push+pop level", {27'd0, fifo_level0}, 32'd16);
        chk("push+pop overrun", {31'd0, overrun0}, 32'd0);
        drive(0, 1'b1, CPB - M - S - 3);
        for (int i = 0; i < 16; i++) pop_check(0, "drain");
        chk("drained level", {27'd0, fifo_level0}, 32'd0);
        chk("final break count", brk_cnt, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver: configurable data width, parity and stop bits, 3-sample majority voting at mid-bit, per-frame error tagging, break detection, and a show-ahead receive FIFO. Runs in the 25.2 MHz pixel-clock domain, so consumers read received words with no clock-domain crossing. Drop-in successor for the single-byte, flag-less receiver on the audio-sample link.

Parameters:
CLK_CYCLES_PER_BIT, 219, clk cycles per bit (25.2 MHz / 115200); must be >= 8
DATA_BITS, 8, data bits per frame, 5..9, LSB first
PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
SYNC_STAGES, 3, synchroniser flops on rx_data, >= 2
FIFO_DEPTH, 16, receive FIFO entries, power of 2, >= 2

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
rx_data  in  1  asynchronous serial line, idle high
rd_en  in  1  pop request; ignored when rd_valid = 0
rd_valid  out  1  FIFO non-empty
rd_data  out  DATA_BITS  head-of-FIFO data word
rd_perr  out  1  head entry had a parity error
rd_ferr  out  1  head entry had a framing error
fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held
break_det  out  1  one-cycle pulse on break detection
overrun  out  1  sticky; set when a frame is dropped because the FIFO is full
err_clr  in  1  clears overrun

Behaviour:
- Reset: FSM to IDLE, FIFO emptied, rd_valid = 0, fifo_level = 0, break_det = 0, overrun = 0. rd_data, rd_perr and rd_ferr are don't-care while rd_valid = 0. Reset mid-frame discards the partial frame.
- rx_data passes through a SYNC_STAGES flop chain (reset to 1); all logic below uses the synchronised line "rxs".
- M = (CLK_CYCLES_PER_BIT-1)/2. Bit counter cnt runs 0..CLK_CYCLES_PER_BIT-1 within each bit. rxs is sampled at cnt = M-1, M and M+1; the bit value is the 2-of-3 majority.
- States: IDLE, START, DATA, PARITY (only if PARITY_MODE != 0), STOP, BREAK_WAIT.
- IDLE: rxs = 0 -> START with cnt = 0 on the next cycle.
- START: at cnt = M+1, if majority = 1 it is a false start -> IDLE, with no push and no flags. Otherwise continue to cnt = CLK_CYCLES_PER_BIT-1, then -> DATA.
- DATA: shift DATA_BITS majority bits, LSB first. After the last bit -> PARITY or STOP.
- PARITY: perr = (majority XOR XOR(data)) != (PARITY_MODE == 1). perr is always 0 when PARITY_MODE = 0.
- STOP: ferr is set if any stop-bit majority = 0. At cnt = M+1 of the final stop bit the frame completes, without waiting for the bit end, so a back-to-back start bit is caught.
  - Break: data all 0, parity bit 0 (if present) and ferr = 1. Pulse break_det, push nothing, go to BREAK_WAIT.
  - Otherwise: push {perr, ferr, data}, then go to IDLE.
- BREAK_WAIT: stay until rxs = 1, then IDLE.
- Push timing: the entry is visible on rd_valid/rd_data one cycle after the completion cycle. Total latency from the rx_data stop-bit midpoint is SYNC_STAGES+2 cycles.
- FIFO is show-ahead: the head is always presented. rd_en & rd_valid pops at the clock edge; the next entry appears the following cycle.
- Push when full:
  - With a pop in the same cycle: pop takes effect first, push is accepted, level unchanged, no overrun.
  - Without a pop: the new frame is dropped, FIFO contents are unchanged, overrun is set.
- overrun: err_clr clears it next cycle. If err_clr and a new overrun occur in the same cycle, the set wins.
- fifo_level: +1 on push, -1 on pop, unchanged on simultaneous push and pop. Read and write pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Default params, 8N1 frame 0x55 at 219 cycles/bit -> rd_valid rises SYNC_STAGES+2 cycles after the stop-bit midpoint; rd_data = 0x55, rd_perr = 0, rd_ferr = 0, fifo_level = 1; rd_en pop -> level 0.
- PARITY_MODE = 2, frame 0xA3 with parity bit 1 (wrong) -> rd_data = 0xA3, rd_perr = 1; repeat with parity bit 0 -> rd_perr = 0.
- 50-cycle low glitch on an idle line -> no push, no flags, FSM back in IDLE; a following 0x3C frame is received correctly.
- Frame 0x81 with stop bit driven 0 -> entry 0x81 with rd_ferr = 1. All-zero frame plus low stop held for 5 bit times -> one break_det pulse, no push, next frame 0x12 received normally.
- Single-cycle inverted glitch at cnt = M of each data bit of 0xF0 -> rd_data = 0xF0 (majority vote rejects the glitch).
- FIFO_DEPTH = 16, 17 back-to-back frames 0x00..0x10 with no reads -> level 16, overrun = 1, reads return 0x00..0x0F. err_clr -> overrun = 0. With FIFO full, a push and pop in the same cycle -> level stays 16, overrun stays 0.
